auto_range_normalizer: RTL and testbench
========================================

AUTO_RANGE_NORMALIZER -- requirements
Module: auto_range_normalizer

Interface
REQ-001 SHALL have parameter DATAW, default 16: signed input pixel width.
REQ-002 SHALL have parameter DEPTH, default 768: pixels per frame; addresses 0..DEPTH-1; ADDRW = $clog2(DEPTH).
REQ-003 SHALL have parameter OUTW, default 8: output pixel width; OMAX = 2^OUTW-1.
REQ-004 SHALL have parameter FRACTIONW, default 12: fractional bits of the scale factor.
REQ-005 SHALL have parameter MIN_RANGE, default 64: floor applied to the range before division.
REQ-006 SHALL have ports i_clk in 1 (clock) and i_rst in 1 (reset); one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports i_start in 1 (start pulse), i_mode in 1 (0 = manual min/range, 1 = auto scan), i_min in DATAW signed, i_range in DATAW unsigned.
REQ-008 SHALL have ports o_rd_valid out 1, o_rd_addr out ADDRW, i_rd_data in DATAW (source memory, read data valid exactly 1 cycle after o_rd_valid).
REQ-009 SHALL have ports o_wr_valid out 1, o_wr_addr out ADDRW, o_wr_data out OUTW (destination memory).
REQ-010 SHALL have ports o_busy out 1, o_done out 1 (1-cycle pulse), o_frame_min out DATAW, o_frame_max out DATAW, o_clip_count out ADDRW+1.

Function
REQ-011 SHALL implement FSM IDLE -> SCAN (auto only) -> DIVIDE -> NORM -> DONE -> IDLE; manual mode goes IDLE -> DIVIDE directly.
REQ-012 IDLE: on i_start, SHALL latch i_mode, i_min and i_range, clear o_clip_count, and assert o_busy from the next cycle; i_start outside IDLE SHALL be ignored.
REQ-013 SCAN: SHALL read addresses 0..DEPTH-1, one per cycle, and track signed min/max; leave after the last read data is captured (DEPTH+1 cycles); then min = scanned min, range = max - min.
REQ-014 The range SHALL be computed in DATAW+1 bits unsigned; if range < MIN_RANGE, range = MIN_RANGE.
REQ-015 DIVIDE: SHALL compute scale = floor((OMAX << FRACTIONW) / range) with an internal restoring divider, 1 quotient bit per cycle, fixed OUTW+FRACTIONW cycles, no divide-by-zero possible.
REQ-016 NORM: SHALL issue reads at addresses 0..DEPTH-1, one per cycle, with no gaps.
REQ-017 Pipeline: stage 1 delta = data - min (DATAW+2 signed); stage 2 product = clamp(delta, 0) * scale; stage 3 result = product >> FRACTIONW.
REQ-018 Output: if delta < 0, o_wr_data = 0; if result > OMAX, o_wr_data = OMAX and o_clip_count increments; otherwise o_wr_data = result.
REQ-019 o_wr_valid SHALL assert exactly 3 cycles after the corresponding o_rd_valid, with o_wr_addr equal to that read address.
REQ-020 DONE SHALL be entered the cycle after the last write; o_done pulses for 1 cycle, o_busy deasserts, and o_frame_min/o_frame_max/o_clip_count hold until the next start.
REQ-021 In manual mode, o_frame_min = i_min and o_frame_max = i_min + range (truncated to DATAW).
REQ-022 An i_start coinciding with o_done SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-023 i_rst SHALL force IDLE and zero all outputs and pipeline valids on the next edge, including mid-SCAN, mid-DIVIDE or mid-NORM; no write SHALL be issued after reset.
REQ-024 After reset release, the first i_start SHALL be accepted normally.

Verification (DATAW=16, OUTW=8, FRACTIONW=12, DEPTH=4 unless stated)
REQ-025 Manual, min=0, range=255, frame {100,-5,300,255}: scale=4096; writes {100,0,255,255}; clip_count=1; o_done once.
REQ-026 Auto, frame {10,20,30,1034}: frame_min=10, frame_max=1034, scale=1020; writes {0,2,4,255}; clip_count=0.
REQ-027 Auto, flat frame {500,500,500,500}: range floored to 64; writes all 0; o_done asserted.
REQ-028 Reset asserted mid-NORM after 2 writes: no further o_wr_valid; all outputs 0; the next start completes normally.
REQ-029 i_start pulsed during SCAN and on the o_done cycle: both ignored; exactly one frame processed.
REQ-030 Timing check, DEPTH=768, auto: o_wr_valid 3 cycles after each o_rd_valid; 768 writes; total busy = 769 + 20 + 768 + 3 cycles ±1.

Source files
------------

// File: rtl/auto_range_normalizer.sv
// auto_range_normalizer
//
// Rescales a frame of signed pixels held in a source memory into unsigned
// OUTW-bit pixels written to a destination memory. The black level (min) and
// span (range) either come from the i_min/i_range ports (manual mode) or are
// found by a scan over the frame (auto mode). A restoring divider computes the
// fixed-point gain OMAX/range once per frame. A second pass then streams every
// pixel through a short pipeline that applies (pixel - min) * gain.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              start pulse, accepted only in IDLE
//   i_mode               0 = manual (i_min/i_range), 1 = auto scan
//   i_min, i_range       manual black level (signed) and span (unsigned)
//   o_rd_valid/o_rd_addr source memory read request
//   i_rd_data            source read data, valid one cycle after o_rd_valid
//   o_wr_valid/o_wr_addr/o_wr_data  destination memory write
//   o_busy               high from the cycle after start until DONE
//   o_done               one-cycle pulse in DONE
//   o_frame_min/max      black level and top of the range used for the frame
//   o_clip_count         number of pixels saturated at OMAX
//   o_dbg_state          current FSM state
//
// Memory handshake: there is no back-pressure. A read request is a single
// cycle with o_rd_valid high; the memory must present the data for that
// address on i_rd_data in the very next cycle. A write is a single cycle with
// o_wr_valid high and must be accepted in that cycle.
module auto_range_normalizer #(
    parameter int DATAW     = 16,
    parameter int DEPTH     = 768,
    parameter int OUTW      = 8,
    parameter int FRACTIONW = 12,
    parameter int MIN_RANGE = 64,
    localparam int ADDRW    = $clog2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic signed [DATAW-1:0] i_min,
    input  logic [DATAW-1:0]        i_range,
    output logic                    o_rd_valid,
    output logic [ADDRW-1:0]        o_rd_addr,
    input  logic [DATAW-1:0]        i_rd_data,
    output logic                    o_wr_valid,
    output logic [ADDRW-1:0]        o_wr_addr,
    output logic [OUTW-1:0]         o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [DATAW-1:0]        o_frame_min,
    output logic [DATAW-1:0]        o_frame_max,
    output logic [ADDRW:0]          o_clip_count,
    output logic [2:0]              o_dbg_state
);

    // Quotient width, range width (range of two signed values needs one more
    // bit), product width.
    localparam int QW = OUTW + FRACTIONW;
    localparam int RW = DATAW + 1;
    localparam int PW = RW + QW;
    localparam int CW = $clog2(QW);

    localparam logic [OUTW-1:0]  OMAX    = '1;
    localparam logic [QW-1:0]    DVD     = {OMAX, {FRACTIONW{1'b0}}};
    localparam logic [RW-1:0]    MINR    = RW'(MIN_RANGE);
    localparam logic [ADDRW-1:0] LAST    = ADDRW'(DEPTH - 1);
    localparam logic [DATAW-1:0] POS_MAX = {1'b0, {(DATAW-1){1'b1}}};
    localparam logic [DATAW-1:0] NEG_MIN = {1'b1, {(DATAW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_DIVIDE = 3'd2,
        S_NORM   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;

    logic                    mode_q;
    logic signed [DATAW-1:0] min_q;
    logic signed [DATAW-1:0] scan_min;
    logic signed [DATAW-1:0] scan_max;
    logic [RW-1:0]           divisor;

    logic [RW-1:0]           div_rem;
    logic [QW-1:0]           div_dvd;
    logic [QW-1:0]           div_quot;
    logic [CW-1:0]           div_cnt;
    logic [QW-1:0]           scale;

    // Read request delayed by one cycle: aligned with i_rd_data.
    logic                    rd_valid_d;
    logic [ADDRW-1:0]        rd_addr_d;

    // Pipeline stage 1: delta = data - min.
    logic                    s1_valid;
    logic [ADDRW-1:0]        s1_addr;
    logic signed [DATAW+1:0] s1_delta;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic signed [DATAW-1:0] rd_sdata;
    logic signed [DATAW-1:0] scan_min_nx;
    logic signed [DATAW-1:0] scan_max_nx;
    logic [RW-1:0]           scan_span;
    logic [RW-1:0]           scan_range;
    logic [RW-1:0]           man_range;
    logic [RW:0]             rem_sh;
    logic                    rem_ge;
    logic [RW-1:0]           rem_nx;
    logic [QW-1:0]           quot_nx;
    logic signed [DATAW+1:0] delta_nx;
    logic [RW-1:0]           mag;
    logic [PW-1:0]           prod;
    logic [PW-1:0]           prod_shr;
    logic                    sat;
    logic                    neg;
    logic [OUTW-1:0]         wr_data_nx;
    logic                    clip_nx;

    always_comb begin
        rd_sdata    = i_rd_data;
        scan_min_nx = (rd_sdata < scan_min) ? rd_sdata : scan_min;
        scan_max_nx = (rd_sdata > scan_max) ? rd_sdata : scan_max;

        // max >= min always, so the sign-extended difference is a
        // non-negative RW-bit value.
        scan_span   = {scan_max_nx[DATAW-1], scan_max_nx}
                    - {scan_min_nx[DATAW-1], scan_min_nx};
        scan_range  = (scan_span < MINR) ? MINR : scan_span;
        man_range   = ({1'b0, i_range} < MINR) ? MINR : {1'b0, i_range};

        // Restoring divider step. The partial remainder is always below the
        // divisor, so after subtraction it fits back into RW bits.
        rem_sh  = {div_rem, div_dvd[QW-1]};
        rem_ge  = (rem_sh >= {1'b0, divisor});
        rem_nx  = rem_ge ? RW'(rem_sh - {1'b0, divisor}) : rem_sh[RW-1:0];
        quot_nx = {div_quot[QW-2:0], rem_ge};

        delta_nx = {{2{rd_sdata[DATAW-1]}}, rd_sdata}
                 - {{2{min_q[DATAW-1]}}, min_q};

        // Product and fraction drop share the output register stage.
        neg        = s1_delta[DATAW+1];
        mag        = neg ? '0 : s1_delta[DATAW:0];
        prod       = PW'(mag) * PW'(scale);
        prod_shr   = prod >> FRACTIONW;
        sat        = (prod_shr > PW'(OMAX));
        wr_data_nx = neg ? '0 : (sat ? OMAX : prod_shr[OUTW-1:0]);
        clip_nx    = s1_valid && !neg && sat;
    end

    assign o_dbg_state = state;

    // ------------------------------------------------------------------
    // FSM, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            mode_q       <= 1'b0;
            min_q        <= '0;
            scan_min     <= '0;
            scan_max     <= '0;
            divisor      <= MINR;
            div_rem      <= '0;
            div_dvd      <= '0;
            div_quot     <= '0;
            div_cnt      <= '0;
            scale        <= '0;
            rd_valid_d   <= 1'b0;
            rd_addr_d    <= '0;
            s1_valid     <= 1'b0;
            s1_addr      <= '0;
            s1_delta     <= '0;
            o_rd_valid   <= 1'b0;
            o_rd_addr    <= '0;
            o_wr_valid   <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_frame_min  <= '0;
            o_frame_max  <= '0;
            o_clip_count <= '0;
        end else begin
            o_done     <= 1'b0;
            rd_valid_d <= o_rd_valid;
            rd_addr_d  <= o_rd_addr;
            // Only NORM reads feed the write pipeline; SCAN reads stop here.
            s1_valid   <= rd_valid_d && (state == S_NORM);
            s1_addr    <= rd_addr_d;
            s1_delta   <= delta_nx;
            o_wr_valid <= s1_valid;
            o_wr_addr  <= s1_addr;
            o_wr_data  <= wr_data_nx;
            if (clip_nx) begin
                o_clip_count <= o_clip_count + (ADDRW+1)'(1);
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        mode_q       <= i_mode;
                        min_q        <= i_min;
                        divisor      <= man_range;
                        o_clip_count <= '0;
                        o_busy       <= 1'b1;
                        scan_min     <= POS_MAX;
                        scan_max     <= NEG_MIN;
                        div_rem      <= '0;
                        div_dvd      <= DVD;
                        div_quot     <= '0;
                        div_cnt      <= '0;
                        if (i_mode) begin
                            state      <= S_SCAN;
                            o_rd_valid <= 1'b1;
                            o_rd_addr  <= '0;
                        end else begin
                            state <= S_DIVIDE;
                        end
                    end
                end

                S_SCAN: begin
                    if (o_rd_valid) begin
                        if (o_rd_addr == LAST) begin
                            o_rd_valid <= 1'b0;
                        end else begin
                            o_rd_addr <= o_rd_addr + ADDRW'(1);
                        end
                    end
                    if (rd_valid_d) begin
                        scan_min <= scan_min_nx;
                        scan_max <= scan_max_nx;
                    end
                    // Data for the last address arrives with no request
                    // outstanding: the scan is complete this cycle.
                    if (rd_valid_d && !o_rd_valid) begin
                        min_q   <= scan_min_nx;
                        divisor <= scan_range;
                        state   <= S_DIVIDE;
                    end
                end

                S_DIVIDE: begin
                    div_rem  <= rem_nx;
                    div_dvd  <= div_dvd << 1;
                    div_quot <= quot_nx;
                    div_cnt  <= div_cnt + CW'(1);
                    if (div_cnt == CW'(QW - 1)) begin
                        scale       <= quot_nx;
                        state       <= S_NORM;
                        o_rd_valid  <= 1'b1;
                        o_rd_addr   <= '0;
                        o_frame_min <= min_q;
                        o_frame_max <= mode_q ? scan_max
                                              : (min_q + divisor[DATAW-1:0]);
                    end
                end

                S_NORM: begin
                    if (o_rd_valid) begin
                        if (o_rd_addr == LAST) begin
                            o_rd_valid <= 1'b0;
                        end else begin
                            o_rd_addr <= o_rd_addr + ADDRW'(1);
                        end
                    end
                    if (o_wr_valid && (o_wr_addr == LAST)) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end
                end

                S_DONE: begin
                    // A start seen here is deliberately dropped.
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auto_range_normalizer.sv
// Testbench for auto_range_normalizer: a DEPTH=4 instance for functional
// frames and a DEPTH=768 instance for full-frame timing. Each instance has a
// source memory model and a scoreboard fed by a reference model of the
// normalisation rules.
module tb_auto_range_normalizer;

    localparam int DS = 4;
    localparam int DL = 768;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- small instance ----------------
    logic               start_s, mode_s;
    logic [15:0]        min_s, range_s;
    logic               rd_valid_s;
    logic [1:0]         rd_addr_s;
    logic [15:0]        rd_data_s = '0;
    logic               wr_valid_s;
    logic [1:0]         wr_addr_s;
    logic [7:0]         wr_data_s;
    logic               busy_s, done_s;
    logic [15:0]        fmin_s, fmax_s;
    logic [2:0]         clip_s;
    logic [2:0]         dbg_s;
    logic [15:0]        mem_s [DS];

    auto_range_normalizer #(.DEPTH(DS)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_mode(mode_s),
        .i_min(min_s), .i_range(range_s),
        .o_rd_valid(rd_valid_s), .o_rd_addr(rd_addr_s), .i_rd_data(rd_data_s),
        .o_wr_valid(wr_valid_s), .o_wr_addr(wr_addr_s), .o_wr_data(wr_data_s),
        .o_busy(busy_s), .o_done(done_s), .o_frame_min(fmin_s),
        .o_frame_max(fmax_s), .o_clip_count(clip_s), .o_dbg_state(dbg_s)
    );

    always @(posedge clk) if (rd_valid_s) rd_data_s <= mem_s[rd_addr_s];

    // ---------------- large instance ----------------
    logic               start_l, mode_l;
    logic [15:0]        min_l, range_l;
    logic               rd_valid_l;
    logic [9:0]         rd_addr_l;
    logic [15:0]        rd_data_l = '0;
    logic               wr_valid_l;
    logic [9:0]         wr_addr_l;
    logic [7:0]         wr_data_l;
    logic               busy_l, done_l;
    logic [15:0]        fmin_l, fmax_l;
    logic [10:0]        clip_l;
    logic [2:0]         dbg_l;
    logic [15:0]        mem_l [DL];

    auto_range_normalizer #(.DEPTH(DL)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_start(start_l), .i_mode(mode_l),
        .i_min(min_l), .i_range(range_l),
        .o_rd_valid(rd_valid_l), .o_rd_addr(rd_addr_l), .i_rd_data(rd_data_l),
        .o_wr_valid(wr_valid_l), .o_wr_addr(wr_addr_l), .o_wr_data(wr_data_l),
        .o_busy(busy_l), .o_done(done_l), .o_frame_min(fmin_l),
        .o_frame_max(fmax_l), .o_clip_count(clip_l), .o_dbg_state(dbg_l)
    );

    always @(posedge clk) if (rd_valid_l) rd_data_l <= mem_l[rd_addr_l];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          frame_q[$];
    logic [31:0] model_q[$];
    logic [15:0] exp_min, exp_max;
    int          exp_clip;

    task automatic model(input bit mode, input int mn, input int rg);
        longint lo, hi, rng, scale, d, r;
        model_q.delete();
        exp_clip = 0;
        if (mode) begin
            lo = frame_q[0];
            hi = frame_q[0];
            foreach (frame_q[i]) begin
                if (frame_q[i] < lo) lo = frame_q[i];
                if (frame_q[i] > hi) hi = frame_q[i];
            end
            rng = hi - lo;
        end else begin
            lo  = mn;
            rng = rg;
        end
        if (rng < 64) rng = 64;
        if (!mode) hi = lo + rng;
        scale = (255 * 4096) / rng;
        foreach (frame_q[i]) begin
            d = frame_q[i] - lo;
            if (d < 0) begin
                r = 0;
            end else begin
                r = (d * scale) / 4096;
                if (r > 255) begin
                    r = 255;
                    exp_clip++;
                end
            end
            model_q.push_back({16'(i), 16'(r)});
        end
        exp_min = 16'(lo);
        exp_max = 16'(hi);
    endtask

    // ---------------- scoreboards ----------------
    logic [31:0] exp_q_s[$];
    logic [31:0] exp_q_l[$];
    logic [31:0] e_s, e_l;
    int wr_cnt_s = 0, done_cnt_s = 0;
    int wr_cnt_l = 0, done_cnt_l = 0, busy_cnt_l = 0;
    int rd_cyc_s [DS];
    int rd_cyc_l [DL];

    always @(negedge clk) begin
        if (rd_valid_s) rd_cyc_s[rd_addr_s] = cyc_n;
        if (wr_valid_s) begin
            wr_cnt_s++;
            check("wr_latency_s", 64'(cyc_n - rd_cyc_s[wr_addr_s]), 3);
            check("wr_expected_s", exp_q_s.size() > 0, 1);
            if (exp_q_s.size() > 0) begin
                e_s = exp_q_s.pop_front();
                check("wr_addr_s", wr_addr_s, e_s[31:16]);
                check("wr_data_s", wr_data_s, e_s[15:0]);
            end
        end
        if (done_s) done_cnt_s++;
    end

    always @(negedge clk) begin
        if (rd_valid_l) rd_cyc_l[rd_addr_l] = cyc_n;
        if (wr_valid_l) begin
            wr_cnt_l++;
            check("wr_latency_l", 64'(cyc_n - rd_cyc_l[wr_addr_l]), 3);
            check("wr_expected_l", exp_q_l.size() > 0, 1);
            if (exp_q_l.size() > 0) begin
                e_l = exp_q_l.pop_front();
                check("wr_addr_l", wr_addr_l, e_l[31:16]);
                check("wr_data_l", wr_data_l, e_l[15:0]);
            end
        end
        if (done_l) done_cnt_l++;
        if (busy_l) busy_cnt_l++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_frame(input int a, input int b, input int c, input int d);
        frame_q = '{a, b, c, d};
    endtask

    task automatic run_s(input bit mode, input int mn, input int rg,
                         input bit inj_scan, input bit inj_done);
        bit got;
        int busy_seen, w0, d0;
        foreach (frame_q[i]) mem_s[i] = 16'(frame_q[i]);
        model(mode, mn, rg);
        exp_q_s = model_q;
        w0 = wr_cnt_s;
        d0 = done_cnt_s;
        @(negedge clk);
        start_s = 1'b1; mode_s = mode; min_s = 16'(mn); range_s = 16'(rg);
        @(negedge clk);
        start_s = 1'b0;
        // The configuration must already be latched.
        mode_s = ~mode; min_s = 16'($urandom); range_s = 16'($urandom);
        check("busy_after_start", busy_s, 1);
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            start_s = inj_scan && (c == 2);
            if (done_s) begin
                got = 1'b1;
                start_s = inj_done;
            end
        end
        check("done_seen", got, 1);
        @(negedge clk);
        start_s = 1'b0;
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_s) busy_seen++;
        end
        check("idle_after_done", busy_seen, 0);
        check("frame_min", fmin_s, exp_min);
        check("frame_max", fmax_s, exp_max);
        check("clip_count", clip_s, exp_clip);
        check("wr_count", wr_cnt_s - w0, DS);
        check("done_pulses", done_cnt_s - d0, 1);
        check("exp_q_empty", exp_q_s.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base, span, mn, rg, w0;
        bit got;
        rst = 1'b1;
        start_s = 1'b0; mode_s = 1'b0; min_s = '0; range_s = '0;
        start_l = 1'b0; mode_l = 1'b0; min_l = '0; range_l = '0;
        for (int i = 0; i < DS; i++) mem_s[i] = '0;
        for (int i = 0; i < DL; i++) mem_l[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        check("rst_rd_valid", rd_valid_s, 0);
        check("rst_wr_valid", wr_valid_s, 0);
        check("rst_frame_min", fmin_s, 0);
        check("rst_frame_max", fmax_s, 0);
        check("rst_clip", clip_s, 0);
        check("rst_busy_l", busy_l, 0);

        // Manual range 255: unity gain, one pixel clipped.
        set_frame(100, -5, 300, 255);
        run_s(1'b0, 0, 255, 1'b0, 1'b0);

        // Auto scan with a 1024 span.
        set_frame(10, 20, 30, 1034);
        run_s(1'b1, 0, 0, 1'b0, 1'b0);

        // Flat frame: range floored.
        set_frame(500, 500, 500, 500);
        run_s(1'b1, 0, 0, 1'b0, 1'b0);

        // Manual zero range: floored, no divide by zero.
        set_frame(0, 63, 64, -1);
        run_s(1'b0, 0, 0, 1'b0, 1'b0);

        // Extreme signed values, auto.
        set_frame(-32768, 32767, 0, -1);
        run_s(1'b1, 0, 0, 1'b0, 1'b0);

        // Starts during SCAN and on the done cycle are dropped.
        set_frame(-40, 7, 900, 33);
        run_s(1'b1, 0, 0, 1'b1, 1'b1);

        // Reset in the middle of NORM after two writes.
        set_frame(100, -5, 300, 255);
        foreach (frame_q[i]) mem_s[i] = 16'(frame_q[i]);
        model(1'b0, 0, 255);
        exp_q_s = model_q;
        w0 = wr_cnt_s;
        @(negedge clk);
        start_s = 1'b1; mode_s = 1'b0; min_s = '0; range_s = 16'd255;
        @(negedge clk);
        start_s = 1'b0;
        for (int c = 0; c < 100 && (wr_cnt_s - w0) < 2; c++) begin
            @(negedge clk);
            #1;
        end
        check("two_writes_before_rst", wr_cnt_s - w0, 2);
        rst = 1'b1;
        exp_q_s.delete();
        @(posedge clk);
        #1;
        check("midrst_busy", busy_s, 0);
        check("midrst_done", done_s, 0);
        check("midrst_wr_valid", wr_valid_s, 0);
        check("midrst_rd_valid", rd_valid_s, 0);
        check("midrst_frame_min", fmin_s, 0);
        check("midrst_frame_max", fmax_s, 0);
        check("midrst_clip", clip_s, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_wr_after_rst", wr_cnt_s - w0, 2);
        set_frame(100, -5, 300, 255);
        run_s(1'b0, 0, 255, 1'b0, 1'b0);

        // Randomized frames in both modes.
        for (int it = 0; it < 12; it++) begin
            base = int'($urandom_range(0, 20000)) - 10000;
            case ($urandom_range(0, 3))
                0: span = 30;
                1: span = 300;
                2: span = 3000;
                default: span = 20000;
            endcase
            frame_q.delete();
            for (int i = 0; i < DS; i++)
                frame_q.push_back(base + int'($urandom_range(0, span)));
            mn = base + int'($urandom_range(0, span / 2)) - span / 4;
            rg = int'($urandom_range(0, span));
            run_s(1'($urandom_range(0, 1)), mn, rg, 1'b0, 1'b0);
        end

        // Full-size frame: latency, write count and busy duration.
        frame_q.delete();
        for (int i = 0; i < DL; i++)
            frame_q.push_back(int'($urandom_range(0, 4000)) - 2000);
        foreach (frame_q[i]) mem_l[i] = 16'(frame_q[i]);
        model(1'b1, 0, 0);
        exp_q_l = model_q;
        @(negedge clk);
        start_l = 1'b1; mode_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (done_l) got = 1'b1;
        end
        check("done_seen_l", got, 1);
        repeat (5) @(negedge clk);
        check("wr_count_l", wr_cnt_l, DL);
        check("done_pulses_l", done_cnt_l, 1);
        check("busy_cycles_l_within_1560pm1",
              (busy_cnt_l >= 1559) && (busy_cnt_l <= 1561), 1);
        check("frame_min_l", fmin_l, exp_min);
        check("frame_max_l", fmax_l, exp_max);
        check("clip_count_l", clip_l, exp_clip);
        check("exp_q_empty_l", exp_q_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
